barrel_shifter_pipe: RTL and testbench
======================================

// Module: barrel_shifter_pipe
// PURPOSE
//  Parametrised, pipelined multi-mode barrel shifter; next generation of our 8-bit combinational shifter.
//  Shifts or rotates a WIDTH-bit word by a per-transaction amount.
//  Modes: logical left, logical right, arithmetic right, rotate left, rotate right.
//  One log2 stage per pipeline register; valid/ready handshake on both sides with per-stage backpressure.
//  Sits between a producer (ALU/datapath front-end) and any valid/ready consumer.
// PARAMETERS
//  WIDTH  8  data width; must be a power of 2, >= 2
//  TAG_W  4  width of user tag carried alongside each transaction, unmodified
//  SHW    $clog2(WIDTH)  localparam: shift-amount width and number of pipeline stages
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      input transaction valid
//  in_ready   out  1      block can accept input this cycle
//  in_data    in   WIDTH  operand
//  in_amt     in   SHW    shift/rotate amount, 0..WIDTH-1
//  in_mode    in   3      000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 reserved
//  in_tag     in   TAG_W  user tag
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  out_data   out  WIDTH  shifted/rotated result
//  out_tag    out  TAG_W  tag of the transaction in out_data
// BEHAVIOUR
//  - Reset (async assert, sync-to-clk deassert by system): all stage valid bits, data, amt, mode and tag regs = 0.
//    Hence out_valid=0, out_data=0, out_tag=0. in_ready=1 on the first cycle after reset.
//  - Transfer on any port occurs when valid && ready are both high at a rising clk edge.
//  - Pipeline: stage k (k=0..SHW-1) applies shift/rotate by 2^k when amt[k]=1, else passes data unchanged.
//    Each stage carries data, amt, mode and tag in its own registers.
//  - Latency: SHW cycles from input transfer to out_valid, with no stall.
//    Throughput: 1 transaction/cycle.
//  - Stage k holds valid v[k]. Stage k loads when ready[k] = !v[k] || ready[k+1]; ready[SHW] = out_ready.
//    in_ready = ready[0]. Bubbles collapse: an empty stage accepts even while downstream is stalled.
//  - Stall: while out_valid && !out_ready, out_data and out_tag are held stable. No transaction is dropped or duplicated.
//  - Fill rules per mode, for a shift of s:
//      SLL: zeros in from the LSB.
//      SRL: zeros in from the MSB.
//      SRA: copies of the ORIGINAL in_data[WIDTH-1] in from the MSB, sign carried through the stages.
//      ROL/ROR: bits wrap around.
//  - amt=0: result equals in_data for every mode, with the same latency SHW.
//  - Reserved modes 101-111: result equals in_data, tag passes through, no error signalled.
//  - amt width equals SHW, so out-of-range amounts are impossible. No modulo logic.
//  - Simultaneous in and out transfer when the pipe is full: both occur and occupancy is unchanged.
//  - Reset mid-operation: all in-flight transactions are discarded.
//    out_valid falls asynchronously on rst_n=0.
// STRUCTURE
//  - Package bs_pkg: localparams MODE_SLL=3'd0, MODE_SRL=3'd1, MODE_SRA=3'd2, MODE_ROL=3'd3, MODE_ROR=3'd4.
//    Also holds the mode width constant MODE_W=3.
//  - Sub-module bs_stage #(WIDTH, TAG_W, SHIFT): one registered log stage.
//    Combinational shift by SHIFT, gated by its amt bit; valid/ready register slice.
//  - Top level generates SHW instances of bs_stage with SHIFT=2^k and chains the ready signals.
// TESTING (WIDTH=8, TAG_W=4)
//  1. Reset with in_valid=1 asserted -> out_valid=0, out_data=0; first result appears exactly 3 cycles after the first accepted input.
//  2. in_data=8'b0011_0111, amt=5, one transaction per mode, out_ready=1 ->
//     SLL=1110_0000, SRL=0000_0001, ROL=1110_0110, ROR=1011_1001.
//  3. SRA with in_data=8'b1011_0111, amt=3 -> 1111_0110. amt=0, mode=SRA -> 1011_0111. mode=3'b111 -> 1011_0111.
//  4. Stream 8 back-to-back inputs, tags 0..7, and hold out_ready=0 for cycles 4-9 ->
//     in_ready=0 once 3 transactions are held; no loss; outputs in tag order 0..7 with correct data.
//  5. Random valid/ready toggling, 1000 transactions, random mode/amt, checked against a reference model ->
//     zero mismatches; tag order is preserved.
//  6. Pulse rst_n low with the pipe full ->
//     out_valid=0 immediately; after release, no stale result emerges and a new transaction returns in 3 cycles.

Source files
------------

// File: rtl/bs_pkg.sv
// Shared constants for the pipelined barrel shifter: mode encodings and widths.
package bs_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_SLL = 3'd0;
  localparam logic [MODE_W-1:0] MODE_SRL = 3'd1;
  localparam logic [MODE_W-1:0] MODE_SRA = 3'd2;
  localparam logic [MODE_W-1:0] MODE_ROL = 3'd3;
  localparam logic [MODE_W-1:0] MODE_ROR = 3'd4;

endpackage

// File: rtl/bs_stage.sv
// One registered log stage of the barrel shifter: conditionally shifts or
// rotates by SHIFT (gated by the matching amount bit) and holds the result in
// a valid/ready register slice.
module bs_stage
  import bs_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int TAG_W = 4,
  parameter  int SHIFT = 1,
  localparam int SHW   = $clog2(WIDTH),
  localparam int BIT   = $clog2(SHIFT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [SHW-1:0]    in_amt,
  input  logic [MODE_W-1:0] in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [SHW-1:0]    out_amt,
  output logic [MODE_W-1:0] out_mode,
  output logic [TAG_W-1:0]  out_tag
);

  logic              valid_q;
  logic [WIDTH-1:0]  data_q, data_d, shifted;
  logic [SHW-1:0]    amt_q;
  logic [MODE_W-1:0] mode_q;
  logic [TAG_W-1:0]  tag_q;

  // Shift/rotate by SHIFT for the requested mode, applied only when this
  // stage's amount bit is set. The MSB of an arithmetic shift is never
  // disturbed, so the original sign travels down the pipe in data[WIDTH-1].
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    shifted = in_data;
    case (in_mode)
      MODE_SLL: shifted = in_data << SHIFT;
      MODE_SRL: shifted = in_data >> SHIFT;
      MODE_SRA: shifted = {{SHIFT{in_data[WIDTH-1]}}, in_data[WIDTH-1:SHIFT]};
      MODE_ROL: shifted = {in_data[WIDTH-1-SHIFT:0], in_data[WIDTH-1:WIDTH-SHIFT]};
      MODE_ROR: shifted = {in_data[SHIFT-1:0], in_data[WIDTH-1:SHIFT]};
      default:  shifted = in_data;  // reserved modes pass data through
    endcase
    data_d = in_amt[BIT] ? shifted : in_data;
  end

  // An empty slot accepts regardless of downstream, so bubbles collapse.
  assign in_ready = !valid_q || out_ready;

  // Register slice: load a new beat (or a bubble) whenever this stage is ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: payload registers are reset too so the outputs read zero after reset, not X.
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      mode_q  <= '0;
      tag_q   <= '0;
    end else if (in_ready) begin
      // NOTE: sequential state uses non-blocking assignment so all stages update together.
      valid_q <= in_valid;
      if (in_valid) begin
        data_q <= data_d;
        amt_q  <= in_amt;
        mode_q <= in_mode;
        tag_q  <= in_tag;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_amt   = amt_q;
  assign out_mode  = mode_q;
  assign out_tag   = tag_q;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined multi-mode barrel shifter: SHW chained log stages, stage k
// shifting by 2^k, with per-stage valid/ready backpressure.
module barrel_shifter_pipe
  import bs_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int TAG_W = 4,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [SHW-1:0]    in_amt,
  input  logic [MODE_W-1:0] in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [TAG_W-1:0]  out_tag
);

  // Index 0 is the block input; index k+1 is the output of stage k.
  logic              valid [SHW+1];
  logic              ready [SHW+1];
  logic [WIDTH-1:0]  data  [SHW+1];
  logic [SHW-1:0]    amt   [SHW+1];
  logic [MODE_W-1:0] mode  [SHW+1];
  logic [TAG_W-1:0]  tag   [SHW+1];

  assign valid[0]   = in_valid;
  assign data[0]    = in_data;
  assign amt[0]     = in_amt;
  assign mode[0]    = in_mode;
  assign tag[0]     = in_tag;
  assign ready[SHW] = out_ready;
  assign in_ready   = ready[0];

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    bs_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W),
      .SHIFT (2 ** k)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (valid[k]),
      .in_ready  (ready[k]),
      .in_data   (data[k]),
      .in_amt    (amt[k]),
      .in_mode   (mode[k]),
      .in_tag    (tag[k]),
      .out_valid (valid[k+1]),
      .out_ready (ready[k+1]),
      .out_data  (data[k+1]),
      .out_amt   (amt[k+1]),
      .out_mode  (mode[k+1]),
      .out_tag   (tag[k+1])
    );
  end

  assign out_valid = valid[SHW];
  assign out_data  = data[SHW];
  assign out_tag   = tag[SHW];

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Self-checking bench for barrel_shifter_pipe (WIDTH=8, TAG_W=4): directed
// vector table, backpressure stream, random handshake stream, mid-run reset.
module tb_barrel_shifter_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic [2:0] in_mode;
  logic [3:0] in_tag;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] out_tag;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] data;
    logic [2:0] amt;
    logic [2:0] mode;
    logic [3:0] tag;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic [3:0] tag;
  } exp_t;

  vec_t vecs[14];

  barrel_shifter_pipe #(.WIDTH(8), .TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-word reference: full shifts and double-width rotates.
  function automatic logic [7:0] ref_model(logic [7:0] x, logic [2:0] a, logic [2:0] m);
    logic [15:0] dbl;
    case (m)
      3'd0: return x << a;
      3'd1: return x >> a;
      3'd2: return 8'($signed(x) >>> a);
      3'd3: begin dbl = {x, x} << a; return dbl[15:8]; end
      3'd4: begin dbl = {x, x} >> a; return dbl[7:0];  end
      default: return x;
    endcase
  endfunction

  // Single transaction into an idle pipe with out_ready=1; checks latency, data, tag.
  task automatic run_one(input vec_t v, input string name);
    int cyc;
    in_data   = v.data;
    in_amt    = v.amt;
    in_mode   = v.mode;
    in_tag    = v.tag;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, "_latency"}, 32'(cyc), 32'd3);
    check({name, "_data"}, 32'(out_data), 32'(v.exp));
    check({name, "_tag"}, 32'(out_tag), 32'(v.tag));
    @(posedge clk); #1;
  endtask

  // Stream n transactions. rnd=0: every cycle valid, out_ready low on cycles 4..9.
  // rnd=1: random valid, ready, data, amt and mode.
  task automatic stream(input int n, input bit rnd, input string name);
    exp_t       q[$];
    exp_t       e;
    int         sent = 0;
    int         got  = 0;
    int         cyc  = 0;
    bit         held = 1'b0;
    bit         saw_bp = 1'b0;
    logic [7:0] held_d;
    logic [3:0] held_t;
    while (got < n && cyc < 20000) begin
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      else     out_ready = !(cyc >= 4 && cyc <= 9);
      if (sent < n && (!rnd || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        in_tag   = 4'(sent);
        if (rnd) begin
          in_data = 8'($urandom);
          in_amt  = 3'($urandom_range(0, 7));
          in_mode = 3'($urandom_range(0, 7));
        end else begin
          in_data = 8'(8'h35 + sent * 8'h1d);
          in_amt  = 3'(sent);
          in_mode = 3'(sent % 5);
        end
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (held) begin
        check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
        check({name, "_hold_data"}, 32'(out_data), 32'(held_d));
        check({name, "_hold_tag"}, 32'(out_tag), 32'(held_t));
      end
      held   = out_valid && !out_ready;
      held_d = out_data;
      held_t = out_tag;
      if (!rnd && in_valid && !in_ready && (sent - got) == 3) saw_bp = 1'b1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check({name, "_spurious_out"}, 32'(out_tag), 32'hffff_ffff);
        end else begin
          e = q.pop_front();
          check({name, "_data"}, 32'(out_data), 32'(e.data));
          check({name, "_tag"}, 32'(out_tag), 32'(e.tag));
        end
        got++;
      end
      if (in_valid && in_ready) begin
        e.data = ref_model(in_data, in_amt, in_mode);
        e.tag  = in_tag;
        q.push_back(e);
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check({name, "_complete"}, 32'(got), 32'(n));
    check({name, "_all_sent"}, 32'(sent), 32'(n));
    if (!rnd) check({name, "_backpressure_at_3"}, 32'(saw_bp), 32'd1);
  endtask

  initial begin
    vec_t v;
    bit   stale;

    // in_data, amt, mode, tag, expected
    vecs[0]  = '{8'h37, 3'd5, 3'd0, 4'h1, 8'hE0};  // SLL 5
    vecs[1]  = '{8'h37, 3'd5, 3'd1, 4'h2, 8'h01};  // SRL 5
    vecs[2]  = '{8'h37, 3'd5, 3'd3, 4'h3, 8'hE6};  // ROL 5
    vecs[3]  = '{8'h37, 3'd5, 3'd4, 4'h4, 8'hB9};  // ROR 5
    vecs[4]  = '{8'hB7, 3'd3, 3'd2, 4'h5, 8'hF6};  // SRA 3, negative
    vecs[5]  = '{8'hB7, 3'd0, 3'd2, 4'h6, 8'hB7};  // SRA 0
    vecs[6]  = '{8'hB7, 3'd5, 3'd7, 4'h7, 8'hB7};  // reserved 111
    vecs[7]  = '{8'h5A, 3'd3, 3'd5, 4'h8, 8'h5A};  // reserved 101
    vecs[8]  = '{8'h81, 3'd1, 3'd0, 4'h9, 8'h02};  // SLL 1 drops MSB
    vecs[9]  = '{8'h80, 3'd7, 3'd1, 4'hA, 8'h01};  // SRL max
    vecs[10] = '{8'h80, 3'd7, 3'd2, 4'hB, 8'hFF};  // SRA max, negative
    vecs[11] = '{8'h7F, 3'd2, 3'd2, 4'hC, 8'h1F};  // SRA positive
    vecs[12] = '{8'h01, 3'd7, 3'd4, 4'hD, 8'h02};  // ROR max
    vecs[13] = '{8'hA5, 3'd0, 3'd3, 4'hE, 8'hA5};  // ROL 0

    // Reset held with in_valid asserted
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    in_amt    = 3'd1;
    in_mode   = 3'd0;
    in_tag    = 4'hF;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Directed vectors, one at a time
    for (int i = 0; i < 14; i++) run_one(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back stream with a downstream stall
    stream(8, 1'b0, "stall");
    repeat (4) @(posedge clk);
    #1;

    // Random handshake stream
    stream(1000, 1'b1, "rand");
    repeat (4) @(posedge clk);
    #1;

    // Fill the pipe with the consumer stalled, then reset mid-run
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(8'h11 * (i + 1));
      in_amt  = 3'(i);
      in_mode = 3'd0;
      in_tag  = 4'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("full_out_valid", 32'(out_valid), 32'd1);
    check("full_in_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_out_data", 32'(out_data), 32'd0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    stale     = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    check("no_stale_after_rst", 32'(stale), 32'd0);
    v = '{8'hC3, 3'd4, 3'd3, 4'h9, 8'h3C};  // ROL 4
    run_one(v, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
